// File: rtl/if_fetch_axi.sv
// Instruction fetch unit: owns the PC, issues one single-beat AXI4 read per
// instruction and presents the selected 32-bit word to the decoder.
module if_fetch_axi #(
  parameter logic [63:0]     RESET_PC = 64'h8000_0000,
  parameter int unsigned     ID_W     = 4,
  parameter logic [ID_W-1:0] AXI_ID   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic [63:0]     pc_next_i,
  output logic [31:0]     inst_o,
  output logic [63:0]     pc_o,
  output logic            inst_valid,
  output logic            fetch_err,
  output logic            fetch_misalign,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [ID_W-1:0] arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  input  logic            rvalid,
  output logic            rready,
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic [ID_W-1:0] rid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;

  state_t      state, state_d;
  logic [63:0] pc, pc_d, pc_o_d;
  logic [31:0] araddr_d, inst_d;
  logic        arvalid_d, rready_d, iv_d, err_d, mis_d;

  // Single outstanding beat, so rlast and rid carry no information.
  logic unused_axi;
  assign unused_axi = ^{rlast, rid};

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b011;
  assign arburst = 2'b01;

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pc_o_d    = pc_o;
    araddr_d  = araddr;
    inst_d    = inst_o;
    arvalid_d = arvalid;
    rready_d  = rready;
    iv_d      = 1'b0;
    err_d     = 1'b0;
    mis_d     = 1'b0;
    case (state)
      IDLE: begin
        if (!stall_i) begin
          if (pc[1:0] != 2'b00) begin
            state_d = OUT;
            inst_d  = NOP;
            mis_d   = 1'b1;
            iv_d    = 1'b1;
            pc_o_d  = pc;
          end else begin
            state_d   = ADDR;
            arvalid_d = 1'b1;
            araddr_d  = {pc[31:3], 3'b000};
          end
        end
      end
      ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (rvalid) begin
          rready_d = 1'b0;
          state_d  = OUT;
          iv_d     = 1'b1;
          pc_o_d   = pc;
          if (rresp != 2'b00) begin
            inst_d = NOP;
            err_d  = 1'b1;
          end else begin
            inst_d = pc[2] ? rdata[63:32] : rdata[31:0];
          end
        end
      end
      OUT: begin
        pc_d    = pc_next_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      pc_o           <= RESET_PC;
      araddr         <= '0;
      inst_o         <= NOP;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      inst_valid     <= 1'b0;
      fetch_err      <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      state          <= state_d;
      pc             <= pc_d;
      pc_o           <= pc_o_d;
      araddr         <= araddr_d;
      inst_o         <= inst_d;
      arvalid        <= arvalid_d;
      rready         <= rready_d;
      inst_valid     <= iv_d;
      fetch_err      <= err_d;
      fetch_misalign <= mis_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_axi.sv
// Self-checking bench for if_fetch_axi: directed table, reset-in-flight
// sequence and randomized fetches against a transaction-level model.
module tb_if_fetch_axi;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall_i;
  logic [63:0] pc_next_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        inst_valid, fetch_err, fetch_misalign;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] model_pc;

  if_fetch_axi #(.RESET_PC(RESET_PC), .ID_W(4), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .pc_next_i(pc_next_i),
    .inst_o(inst_o), .pc_o(pc_o), .inst_valid(inst_valid),
    .fetch_err(fetch_err), .fetch_misalign(fetch_misalign),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall;
    int          ar_dly;
    int          r_dly;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [63:0] pcn;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic        e_err;
    logic        e_mis;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: word selected by address bit 2 of the PC, replaced by NOP on faults.
  function automatic logic [31:0] ref_inst(input logic [63:0] pc, input logic [63:0] rd,
                                           input logic [1:0] rs);
    logic [63:0] sh;
    if ((pc % 4) != 0 || rs != 2'b00) return NOP;
    sh = rd >> (32 * ((pc / 4) % 2));
    return sh[31:0];
  endfunction

  task automatic run_txn(input int stall, input int ar_dly, input int r_dly,
                         input logic [63:0] rd, input logic [1:0] rs,
                         input logic [63:0] pcn, input logic [63:0] e_pc,
                         input logic [31:0] e_inst, input logic e_err, input logic e_mis);
    int ar_seen = 0, ar_hs = 0, bad_addr = 0, ar_wait = 0, r_wait = 0, lat = 0;
    bit got = 0, ar_done = 0, ar_next = 0;
    logic [31:0] e_addr;
    e_addr    = {e_pc[31:3], 3'b000};
    pc_next_i = pcn;
    rdata     = rd;
    rresp     = rs;
    stall_i   = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (arvalid) ar_seen++;
    end
    chk("ar_during_stall", ar_seen, 0);
    stall_i = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (inst_valid) begin
        got = 1;
        lat = k;
        break;
      end
      ar_done = ar_done | ar_next;
      ar_next = 0;
      if (ar_done) begin
        if (r_wait >= r_dly) rvalid = 1'b1;
        r_wait++;
      end
      if (arvalid) begin
        if (araddr !== e_addr) bad_addr++;
        arready = (ar_wait >= ar_dly);
        ar_wait++;
        if (arready) begin
          ar_hs++;
          ar_next = 1;
        end
      end else begin
        arready = 1'b0;
      end
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    chk("inst_valid_seen", got, 1);
    chk("latency", lat, e_mis ? 1 : 3 + ar_dly + r_dly);
    chk("inst_o", inst_o, e_inst);
    chk("pc_o", pc_o, e_pc);
    chk("fetch_err", fetch_err, e_err);
    chk("fetch_misalign", fetch_misalign, e_mis);
    chk("ar_count", ar_hs, e_mis ? 0 : 1);
    chk("araddr_stable", bad_addr, 0);
    @(negedge clk);
    chk("pulse_clear", {inst_valid, fetch_err, fetch_misalign, arvalid, rready}, 0);
    model_pc = pcn;
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 64'hAAAA_BBBB_0010_0093, 2'b00, 64'h8000_0004,
               64'h8000_0000, 32'h0010_0093, 1'b0, 1'b0};
    tbl[1] = '{0, 0, 0, 64'hAAAA_BBBB_0010_0093, 2'b00, 64'h8000_0008,
               64'h8000_0004, 32'hAAAA_BBBB, 1'b0, 1'b0};
    tbl[2] = '{0, 5, 3, 64'h1111_2222_3333_4444, 2'b00, 64'h8000_000C,
               64'h8000_0008, 32'h3333_4444, 1'b0, 1'b0};
    tbl[3] = '{0, 0, 0, 64'h5555_6666_7777_8888, 2'b10, 64'h8000_0002,
               64'h8000_000C, NOP, 1'b1, 1'b0};
    tbl[4] = '{0, 0, 0, 64'h5555_6666_7777_8888, 2'b00, 64'h8000_0010,
               64'h8000_0002, NOP, 1'b0, 1'b1};
    tbl[5] = '{4, 1, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 64'hFFFF_FFFF_0000_1004,
               64'h8000_0010, 32'h89AB_CDEF, 1'b0, 1'b0};
    tbl[6] = '{0, 0, 2, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 64'h8000_0100,
               64'hFFFF_FFFF_0000_1004, 32'hDEAD_BEEF, 1'b0, 1'b0};

    rst = 1'b1; stall_i = 1'b0; pc_next_i = '0; arready = 1'b0; rvalid = 1'b0;
    rdata = '0; rresp = 2'b00; rlast = 1'b1; rid = '0;
    model_pc = RESET_PC;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {arvalid, rready, inst_valid, fetch_err, fetch_misalign}, 0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_pc_o", pc_o, RESET_PC);
    chk("ar_const", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b011, 2'b01});
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].stall, tbl[i].ar_dly, tbl[i].r_dly, tbl[i].rdata, tbl[i].rresp,
              tbl[i].pcn, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_err, tbl[i].e_mis);

    // Stall in IDLE, then reset while the read beat is still outstanding.
    begin
      int ar_seen = 0;
      bit in_data = 0;
      stall_i = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (arvalid) ar_seen++;
      end
      chk("t6_stall_noar", ar_seen, 0);
      stall_i = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rready) begin
          in_data = 1;
          break;
        end
        arready = arvalid;
      end
      arready = 1'b0;
      chk("t6_reached_data", in_data, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_ctrl", {arvalid, rready, inst_valid}, 0);
      chk("t6_rst_pc_o", pc_o, RESET_PC);
      rst = 1'b0;
      model_pc = RESET_PC;
      run_txn(0, 0, 0, 64'h0BAD_F00D_0000_0517, 2'b00, 64'h8000_0004,
              model_pc, ref_inst(model_pc, 64'h0BAD_F00D_0000_0517, 2'b00), 1'b0, 1'b0);
    end

    for (int n = 0; n < 40; n++) begin
      logic [63:0] rd, pcn, cur;
      logic [1:0]  rs;
      bit          mis;
      rd  = {$urandom, $urandom};
      rs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      pcn = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) pcn = pcn - (pcn % 4);
      cur = model_pc;
      mis = (cur % 4) != 0;
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rd, rs,
              pcn, cur, ref_inst(cur, rd, rs), !mis && rs != 2'b00, mis);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
